// File: rtl/ovi_vector_responder.sv
// ovi_vector_responder: vector-side OVI issue/complete responder that queues issues, models latency and completes them in order.
// Ports: CLK/RST (async active-high); ISSUE_VALID/INSTR/VL/SEW in; ISSUE_CREDIT, COMPLETED_VALID/ILLEGAL/INSTR, BUSY, ERR_OVERFLOW out.
// Optional OVI_RESP_PERF_EN adds PERF_BUSY_CYCLES (32b) and PERF_COMPLETED (16b).
`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 8
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 2
`endif
module ovi_vector_responder #(
  parameter int DEPTH    = 4,
  parameter int LANES    = 4,
  parameter int BASE_LAT = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ISSUE_VALID,
  input  logic [`OVI_INSTR_WIDTH-1:0] ISSUE_INSTR,
  input  logic [`OVI_VL_WIDTH-1:0]    ISSUE_VL,
  input  logic [`OVI_SEW_WIDTH-1:0]   ISSUE_SEW,
  output logic                        ISSUE_CREDIT,
  output logic                        COMPLETED_VALID,
  output logic                        COMPLETED_ILLEGAL,
  output logic [`OVI_INSTR_WIDTH-1:0] COMPLETED_INSTR,
  output logic                        BUSY,
  output logic                        ERR_OVERFLOW
`ifdef OVI_RESP_PERF_EN
  ,
  output logic [31:0]                 PERF_BUSY_CYCLES,
  output logic [15:0]                 PERF_COMPLETED
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = `OVI_INSTR_WIDTH;
  localparam int VW = `OVI_VL_WIDTH;
  localparam int SW = `OVI_SEW_WIDTH;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] q_instr [DEPTH];
  logic [VW-1:0] q_vl [DEPTH];
  logic [SW-1:0] q_sew [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] lat_q, lat_d, raw_lat, head_lat;
  logic [IW-1:0] instr_q, instr_d, cinstr_q, cinstr_d;
  logic ill_q, ill_d, credit_q, err_q, err_d;
  logic pop, push, head_ill;
  always_comb begin
    // DONE may pop too, so the next instruction starts on the edge that leaves DONE
    pop = (state_q != EXEC) && (cnt_q != '0);
    push = ISSUE_VALID && ((cnt_q != (AW+1)'(DEPTH)) || pop);
    err_d = err_q | (ISSUE_VALID & ~push);
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    head_ill = (q_instr[rd_q][6:0] != 7'h57) || (q_sew[rd_q] == SW'(3));
    raw_lat = 32'(BASE_LAT) + ((32'(q_vl[rd_q]) + 32'(LANES - 1)) >> $clog2(LANES));
    head_lat = (raw_lat == 32'd0) ? 32'd1 : raw_lat;
    instr_d = pop ? q_instr[rd_q] : instr_q;
    ill_d = pop ? head_ill : ill_q;
    lat_d = pop ? head_lat - 32'd1 : (state_q == EXEC && lat_q != 32'd0) ? lat_q - 32'd1 : lat_q;
    state_d = pop ? (head_ill ? DONE : EXEC) : (state_q == EXEC) ? ((lat_q == 32'd0) ? DONE : EXEC) : IDLE;
    cinstr_d = (state_d == DONE) ? instr_d : cinstr_q;
  end
  always_ff @(posedge CLK)
    if (push) begin
      q_instr[wr_q] <= ISSUE_INSTR;
      q_vl[wr_q] <= ISSUE_VL;
      q_sew[wr_q] <= ISSUE_SEW;
    end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      lat_q <= '0;
      instr_q <= '0;
      cinstr_q <= '0;
      ill_q <= 1'b0;
      credit_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      instr_q <= instr_d;
      cinstr_q <= cinstr_d;
      ill_q <= ill_d;
      credit_q <= pop;
      err_q <= err_d;
    end
  assign ISSUE_CREDIT = credit_q;
  assign COMPLETED_VALID = (state_q == DONE);
  assign COMPLETED_ILLEGAL = (state_q == DONE) && ill_q;
  assign COMPLETED_INSTR = cinstr_q;
  assign BUSY = (cnt_q != '0) || (state_q != IDLE);
  assign ERR_OVERFLOW = err_q;
`ifdef OVI_RESP_PERF_EN
  logic [31:0] pbusy_q;
  logic [15:0] pcomp_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pbusy_q <= '0;
      pcomp_q <= '0;
    end else begin
      pbusy_q <= pbusy_q + 32'(state_q != IDLE);
      pcomp_q <= pcomp_q + 16'(state_q == DONE);
    end
  assign PERF_BUSY_CYCLES = pbusy_q;
  assign PERF_COMPLETED = pcomp_q;
`endif
endmodule

// File: tb/tb_ovi_vector_responder.sv
// tb_ovi_vector_responder: directed self-checking bench for ovi_vector_responder (optional OVI_RESP_PERF_EN counters checked when defined).
`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 8
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 2
`endif
module tb_ovi_vector_responder;
  logic CLK = 1'b0, RST = 1'b1, ISSUE_VALID = 1'b0;
  logic [`OVI_INSTR_WIDTH-1:0] ISSUE_INSTR = '0;
  logic [`OVI_VL_WIDTH-1:0] ISSUE_VL = '0;
  logic [`OVI_SEW_WIDTH-1:0] ISSUE_SEW = '0;
  logic ISSUE_CREDIT, COMPLETED_VALID, COMPLETED_ILLEGAL, BUSY, ERR_OVERFLOW;
  logic [`OVI_INSTR_WIDTH-1:0] COMPLETED_INSTR;
`ifdef OVI_RESP_PERF_EN
  logic [31:0] PERF_BUSY_CYCLES;
  logic [15:0] PERF_COMPLETED;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int comp_cyc[$], cred_cyc[$];
  logic [31:0] comp_ins[$];
  logic comp_ill[$];
  ovi_vector_responder dut (
    .CLK(CLK), .RST(RST), .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR),
    .ISSUE_VL(ISSUE_VL), .ISSUE_SEW(ISSUE_SEW), .ISSUE_CREDIT(ISSUE_CREDIT),
    .COMPLETED_VALID(COMPLETED_VALID), .COMPLETED_ILLEGAL(COMPLETED_ILLEGAL),
    .COMPLETED_INSTR(COMPLETED_INSTR), .BUSY(BUSY), .ERR_OVERFLOW(ERR_OVERFLOW)
`ifdef OVI_RESP_PERF_EN
    , .PERF_BUSY_CYCLES(PERF_BUSY_CYCLES), .PERF_COMPLETED(PERF_COMPLETED)
`endif
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK)
    if (!RST) begin
      if (COMPLETED_VALID) begin
        comp_cyc.push_back(cyc);
        comp_ins.push_back(COMPLETED_INSTR);
        comp_ill.push_back(COMPLETED_ILLEGAL);
      end
      if (ISSUE_CREDIT) cred_cyc.push_back(cyc);
    end
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask
  task automatic clear_log();
    comp_cyc.delete(); cred_cyc.delete(); comp_ins.delete(); comp_ill.delete();
  endtask
  task automatic issue(input logic [31:0] ins, input int vl, input int sew, output int e);
    ISSUE_VALID = 1'b1; ISSUE_INSTR = ins; ISSUE_VL = `OVI_VL_WIDTH'(vl); ISSUE_SEW = `OVI_SEW_WIDTH'(sew);
    e = cyc + 1;
    tick(1);
    ISSUE_VALID = 1'b0;
  endtask
  task automatic do_reset();
    ISSUE_VALID = 1'b0; RST = 1'b1;
    tick(2);
    RST = 1'b0;
    clear_log();
  endtask
  task automatic test_reset();
    tick(2);
    checks++; if (ISSUE_CREDIT !== 1'b0) begin errors++; $display("FAIL reset_credit: got %b expected 0", ISSUE_CREDIT); end
    checks++; if (COMPLETED_VALID !== 1'b0) begin errors++; $display("FAIL reset_cvalid: got %b expected 0", COMPLETED_VALID); end
    checks++; if (COMPLETED_ILLEGAL !== 1'b0) begin errors++; $display("FAIL reset_cill: got %b expected 0", COMPLETED_ILLEGAL); end
    checks++; if (COMPLETED_INSTR !== 32'h0) begin errors++; $display("FAIL reset_cinstr: got %h expected 0", COMPLETED_INSTR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (ERR_OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ERR_OVERFLOW); end
    RST = 1'b0;
    clear_log();
  endtask
  task automatic test_single_legal();
    int e;
    do_reset();
    issue(32'h02208057, 8, 2, e);
    tick(10);
    checks++; if (cred_cyc.size() != 1) begin errors++; $display("FAIL single_credits: got %0d expected 1", cred_cyc.size()); end
    else begin checks++; if (cred_cyc[0] != e + 1) begin errors++; $display("FAIL single_credit_cyc: got %0d expected %0d", cred_cyc[0], e + 1); end end
    checks++; if (comp_cyc.size() != 1) begin errors++; $display("FAIL single_comps: got %0d expected 1", comp_cyc.size()); end
    else begin
      checks++; if (comp_cyc[0] != e + 5) begin errors++; $display("FAIL single_comp_cyc: got %0d expected %0d", comp_cyc[0], e + 5); end
      checks++; if (comp_ill[0] !== 1'b0) begin errors++; $display("FAIL single_ill: got %b expected 0", comp_ill[0]); end
      checks++; if (comp_ins[0] !== 32'h02208057) begin errors++; $display("FAIL single_instr: got %h expected 02208057", comp_ins[0]); end
    end
    checks++; if (COMPLETED_INSTR !== 32'h02208057) begin errors++; $display("FAIL single_instr_hold: got %h expected 02208057", COMPLETED_INSTR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", BUSY); end
`ifdef OVI_RESP_PERF_EN
    checks++; if (PERF_BUSY_CYCLES !== 32'd5) begin errors++; $display("FAIL perf_busy: got %0d expected 5", PERF_BUSY_CYCLES); end
    checks++; if (PERF_COMPLETED !== 16'd1) begin errors++; $display("FAIL perf_comp: got %0d expected 1", PERF_COMPLETED); end
`endif
  endtask
  task automatic test_illegal();
    int e1, e2;
    do_reset();
    issue(32'h00000013, 4, 0, e1);
    issue(32'h02208057, 4, 3, e2);
    tick(6);
    checks++; if (comp_cyc.size() != 2) begin errors++; $display("FAIL illegal_comps: got %0d expected 2", comp_cyc.size()); end
    else begin
      checks++; if (comp_cyc[0] != e1 + 1) begin errors++; $display("FAIL illegal_cyc0: got %0d expected %0d", comp_cyc[0], e1 + 1); end
      checks++; if (comp_cyc[1] != e2 + 1) begin errors++; $display("FAIL illegal_cyc1: got %0d expected %0d", comp_cyc[1], e2 + 1); end
      checks++; if (comp_ill[0] !== 1'b1) begin errors++; $display("FAIL illegal_opcode_flag: got %b expected 1", comp_ill[0]); end
      checks++; if (comp_ill[1] !== 1'b1) begin errors++; $display("FAIL illegal_sew_flag: got %b expected 1", comp_ill[1]); end
      checks++; if (comp_ins[0] !== 32'h00000013) begin errors++; $display("FAIL illegal_instr0: got %h expected 00000013", comp_ins[0]); end
    end
    checks++; if (cred_cyc.size() != 2) begin errors++; $display("FAIL illegal_credits: got %0d expected 2", cred_cyc.size()); end
  endtask
  task automatic test_vl_bounds();
    int vls[3] = '{0, 1, 5};
    int lats[3] = '{2, 3, 4};
    int e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_log();
      issue(32'h00000057 | (32'(i) << 12), vls[i], 0, e);
      tick(10);
      checks++; if (comp_cyc.size() != 1) begin errors++; $display("FAIL vl%0d_comps: got %0d expected 1", vls[i], comp_cyc.size()); end
      else begin checks++; if (comp_cyc[0] != e + 1 + lats[i]) begin errors++; $display("FAIL vl%0d_comp_cyc: got %0d expected %0d", vls[i], comp_cyc[0], e + 1 + lats[i]); end end
    end
  endtask
  task automatic test_overflow();
    int e[6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(32'h00000057 | (32'(i) << 12), 16, 1, e[i]);
      if (i == 4) begin checks++; if (ERR_OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ERR_OVERFLOW); end end
    end
    checks++; if (ERR_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ERR_OVERFLOW); end
    tick(50);
    checks++; if (comp_cyc.size() != 5) begin errors++; $display("FAIL ovf_comps: got %0d expected 5", comp_cyc.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (comp_ins[i] !== (32'h00000057 | (32'(i) << 12))) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", i, comp_ins[i], 32'h00000057 | (32'(i) << 12)); end
      checks++; if (comp_cyc[i] != e[0] + 7 + 7 * i) begin errors++; $display("FAIL ovf_cyc%0d: got %0d expected %0d", i, comp_cyc[i], e[0] + 7 + 7 * i); end
    end
    checks++; if (cred_cyc.size() != 5) begin errors++; $display("FAIL ovf_credits: got %0d expected 5", cred_cyc.size()); end
    else begin checks++; if (cred_cyc[4] != e[0] + 29) begin errors++; $display("FAIL ovf_credit_cyc: got %0d expected %0d", cred_cyc[4], e[0] + 29); end end
    checks++; if (ERR_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ERR_OVERFLOW); end
  endtask
  task automatic test_full_pop();
    int e0, e, n;
    do_reset();
    issue(32'h00000057, 16, 1, e0);
    for (int i = 1; i < 5; i++) issue(32'h00000057 | (32'(i) << 12), 16, 1, e);
    n = 0;
    while (!COMPLETED_VALID && n < 20) begin tick(1); n++; end
    checks++; if (COMPLETED_VALID !== 1'b1) begin errors++; $display("FAIL fullpop_wait: got %b expected 1 within 20 cycles", COMPLETED_VALID); end
    issue(32'hABC00057, 16, 1, e);
    checks++; if (e != e0 + 8) begin errors++; $display("FAIL fullpop_edge: got %0d expected %0d", e, e0 + 8); end
    checks++; if (ERR_OVERFLOW !== 1'b0) begin errors++; $display("FAIL fullpop_err: got %b expected 0", ERR_OVERFLOW); end
    tick(60);
    checks++; if (comp_cyc.size() != 6) begin errors++; $display("FAIL fullpop_comps: got %0d expected 6", comp_cyc.size()); end
    else begin
      checks++; if (comp_ins[5] !== 32'hABC00057) begin errors++; $display("FAIL fullpop_last_instr: got %h expected abc00057", comp_ins[5]); end
      checks++; if (comp_cyc[5] != e0 + 42) begin errors++; $display("FAIL fullpop_last_cyc: got %0d expected %0d", comp_cyc[5], e0 + 42); end
    end
    checks++; if (cred_cyc.size() != 6) begin errors++; $display("FAIL fullpop_credits: got %0d expected 6", cred_cyc.size()); end
  endtask
  task automatic test_reset_mid();
    int e;
    do_reset();
    for (int i = 0; i < 4; i++) issue(32'h00000057 | (32'(i) << 12), 16, 1, e);
    tick(1);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", BUSY); end
    #2 RST = 1'b1;
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", BUSY); end
    checks++; if (COMPLETED_VALID !== 1'b0) begin errors++; $display("FAIL rmid_cvalid: got %b expected 0", COMPLETED_VALID); end
    checks++; if (ISSUE_CREDIT !== 1'b0) begin errors++; $display("FAIL rmid_credit: got %b expected 0", ISSUE_CREDIT); end
    checks++; if (COMPLETED_INSTR !== 32'h0) begin errors++; $display("FAIL rmid_cinstr: got %h expected 0", COMPLETED_INSTR); end
    tick(2);
    RST = 1'b0;
    clear_log();
    tick(40);
    checks++; if (comp_cyc.size() != 0) begin errors++; $display("FAIL rmid_ghost_comps: got %0d expected 0", comp_cyc.size()); end
    checks++; if (cred_cyc.size() != 0) begin errors++; $display("FAIL rmid_ghost_credits: got %0d expected 0", cred_cyc.size()); end
    issue(32'h02208057, 8, 2, e);
    tick(10);
    checks++; if (comp_cyc.size() != 1) begin errors++; $display("FAIL rmid_fresh_comps: got %0d expected 1", comp_cyc.size()); end
    else begin checks++; if (comp_cyc[0] != e + 5) begin errors++; $display("FAIL rmid_fresh_cyc: got %0d expected %0d", comp_cyc[0], e + 5); end end
    checks++; if (cred_cyc.size() != 1) begin errors++; $display("FAIL rmid_fresh_credits: got %0d expected 1", cred_cyc.size()); end
    else begin checks++; if (cred_cyc[0] != e + 1) begin errors++; $display("FAIL rmid_fresh_credit_cyc: got %0d expected %0d", cred_cyc[0], e + 1); end end
  endtask
  initial begin
    test_reset();
    test_single_legal();
    test_illegal();
    test_vl_bounds();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
